// File: rtl/cache_bank_scheduler_pkg.sv
// Shared definitions for the cache bank scheduler: lane count, flush FSM states, op encoding.
// Width macros normally come from globalVariables.v; fallbacks keep the slice standalone.
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package cache_bank_scheduler_pkg;

    localparam int LANES   = 4;
    localparam int DEF_ADR = `CACHE_BANK_ADDRESS_WIDTH;
    localparam int DEF_DAT = `DATA_WIDTH;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        ACK   = 2'd3
    } schedState_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } schedOp_t;

endpackage

// File: rtl/cache_sched_arb.sv
// Read/write pick for the bank: one op per cycle, alternating on conflict via the last issued op.
module cache_sched_arb
    import cache_bank_scheduler_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic wrReq,
    input  logic rdAny,
    output logic doWrite,
    output logic doRead
);

    schedOp_t lastOp;

    always_comb begin
        doWrite = 1'b0;
        doRead  = 1'b0;
        if (enable) begin
            if (wrReq && (!rdAny || lastOp == OP_READ)) begin
                doWrite = 1'b1;
            end else if (rdAny) begin
                doRead = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lastOp <= OP_READ;
        end else if (doWrite) begin
            lastOp <= OP_WRITE;
        end else if (doRead) begin
            lastOp <= OP_READ;
        end
    end

endmodule

// File: rtl/cache_bank_scheduler.sv
// Cache bank sequencer: arbitrates 4 read lanes and a fill write onto one bank, returns data and
// line-valid one cycle after grant, and runs the flush FSM. Optional perf counters: CACHE_SCHED_PERF_EN.
module cache_bank_scheduler
    import cache_bank_scheduler_pkg::*;
#(
    parameter int ADR = DEF_ADR,
    parameter int DAT = DEF_DAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LANES-1:0]     rd_req,
    input  logic [LANES*ADR-1:0] rd_addr,
    output logic [LANES-1:0]     rd_gnt,
    output logic [LANES-1:0]     rd_rsp_valid,
    output logic [LANES*DAT-1:0] rd_rsp_data,
    output logic [LANES-1:0]     rd_rsp_line_valid,
    input  logic                 wr_req,
    input  logic [ADR-1:0]       wr_addr,
    input  logic [DAT-1:0]       wr_data,
    output logic                 wr_gnt,
    input  logic                 flush_req,
    output logic                 flush_ack,
    output logic                 busy,
    output logic                 ram_we,
    output logic                 ram_re,
    output logic                 ram_rst,
    output logic [ADR-1:0]       ram_waddr,
    output logic [DAT-1:0]       ram_wdata,
    output logic [LANES*ADR-1:0] ram_raddr,
    input  logic [LANES*DAT-1:0] ram_dout,
    input  logic [LANES-1:0]     ram_unwritten,
`ifdef CACHE_SCHED_PERF_EN
    output logic [31:0]          perf_rd_ops,
    output logic [31:0]          perf_wr_ops,
    output logic [31:0]          perf_conflicts,
`endif
    output schedState_t          dbgState
);

    schedState_t      state;
    schedState_t      stateNext;
    logic             issueEn;
    logic             doWrite;
    logic             doRead;
    logic [LANES-1:0] rspMask;

    // A pending flush blocks new grants so the bank drains before it is cleared.
    assign issueEn = reset && (state == RUN) && !flush_req;

    cache_sched_arb uArb (
        .clk     (clk),
        .reset   (reset),
        .enable  (issueEn),
        .wrReq   (wr_req),
        .rdAny   (|rd_req),
        .doWrite (doWrite),
        .doRead  (doRead)
    );

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (flush_req) stateNext = DRAIN;
            DRAIN:   stateNext = CLEAR;
            CLEAR:   stateNext = ACK;
            ACK:     stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RUN;
            rspMask <= '0;
        end else begin
            state   <= stateNext;
            rspMask <= rd_gnt;
        end
    end

    always_comb begin
        ram_raddr = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rd_gnt[i]) ram_raddr[i*ADR +: ADR] = rd_addr[i*ADR +: ADR];
        end
    end

    assign rd_gnt            = doRead ? rd_req : '0;
    assign wr_gnt            = doWrite;
    assign ram_we            = doWrite;
    assign ram_re            = doRead;
    assign ram_rst           = !reset || (state == CLEAR);
    assign ram_waddr         = wr_addr;
    assign ram_wdata         = wr_data;
    assign busy              = (state != RUN);
    assign flush_ack         = reset && (state == ACK);
    assign rd_rsp_valid      = rspMask;
    assign rd_rsp_data       = ram_dout;
    assign rd_rsp_line_valid = ~ram_unwritten & rspMask;
    assign dbgState          = state;

`ifdef CACHE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset || state == CLEAR) begin
            perf_rd_ops    <= '0;
            perf_wr_ops    <= '0;
            perf_conflicts <= '0;
        end else begin
            if (doRead && perf_rd_ops != '1) perf_rd_ops <= perf_rd_ops + 32'd1;
            if (doWrite && perf_wr_ops != '1) perf_wr_ops <= perf_wr_ops + 32'd1;
            if (wr_req && (|rd_req) && perf_conflicts != '1) perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_bank_scheduler.sv
// Bench for cache_bank_scheduler: a bank RAM fixture, a cycle-level reference model with an
// expected-response queue, directed scenarios followed by randomized held requests.
module tb_cache_bank_scheduler;
    import cache_bank_scheduler_pkg::*;

    localparam int ADR = DEF_ADR;
    localparam int DAT = DEF_DAT;
    localparam int NLINES = 2 ** ADR;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [LANES-1:0]     rdReq;
    logic [LANES*ADR-1:0] rdAddr;
    logic [LANES-1:0]     rdGnt, rspValid, rspLineValid;
    logic [LANES*DAT-1:0] rspData;
    logic                 wrReq, wrGnt;
    logic [ADR-1:0]       wrAddr;
    logic [DAT-1:0]       wrData;
    logic                 flushReq, flushAck, busy;
    logic                 ramWe, ramRe, ramRst;
    logic [ADR-1:0]       ramWaddr;
    logic [DAT-1:0]       ramWdata;
    logic [LANES*ADR-1:0] ramRaddr;
    logic [LANES*DAT-1:0] ramDout;
    logic [LANES-1:0]     ramUnwritten;
    schedState_t          dbgState;
`ifdef CACHE_SCHED_PERF_EN
    logic [31:0]          perfRd, perfWr, perfConf;
`endif

    cache_bank_scheduler #(.ADR(ADR), .DAT(DAT)) dut (
        .clk               (clk),
        .reset             (reset),
        .rd_req            (rdReq),
        .rd_addr           (rdAddr),
        .rd_gnt            (rdGnt),
        .rd_rsp_valid      (rspValid),
        .rd_rsp_data       (rspData),
        .rd_rsp_line_valid (rspLineValid),
        .wr_req            (wrReq),
        .wr_addr           (wrAddr),
        .wr_data           (wrData),
        .wr_gnt            (wrGnt),
        .flush_req         (flushReq),
        .flush_ack         (flushAck),
        .busy              (busy),
        .ram_we            (ramWe),
        .ram_re            (ramRe),
        .ram_rst           (ramRst),
        .ram_waddr         (ramWaddr),
        .ram_wdata         (ramWdata),
        .ram_raddr         (ramRaddr),
        .ram_dout          (ramDout),
        .ram_unwritten     (ramUnwritten),
`ifdef CACHE_SCHED_PERF_EN
        .perf_rd_ops       (perfRd),
        .perf_wr_ops       (perfWr),
        .perf_conflicts    (perfConf),
`endif
        .dbgState          (dbgState)
    );

    // ---------------- bank RAM fixture (writes and reads land at the edge) ----------------
    logic [DAT-1:0]    bankMem [NLINES];
    logic [NLINES-1:0] bankWritten;

    always @(posedge clk) begin
        if (ramRst) begin
            bankWritten <= '0;
        end else if (ramWe) begin
            bankMem[ramWaddr]     <= ramWdata;
            bankWritten[ramWaddr] <= 1'b1;
        end
        if (ramRe) begin
            for (int l = 0; l < LANES; l++) begin
                ramDout[l*DAT +: DAT] <= bankMem[ramRaddr[l*ADR +: ADR]];
                ramUnwritten[l]       <= !bankWritten[ramRaddr[l*ADR +: ADR]];
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [DAT-1:0]    refMem [NLINES];
    logic [NLINES-1:0] refWritten;
    int                phase;      // 0 running, 1 drain, 2 clear, 3 ack
    bit                lastWrite;
    logic [LANES-1:0]  prevGnt;
    logic [DAT:0]      exp_q[$];   // {line_valid, data} per granted lane, lane order

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: predict at negedge, compare, advance model, drop granted requests after the edge.
    task automatic tick(input bit doCheck);
        logic [LANES-1:0]     expRd, dropRd;
        logic                 expWr, expAck, expBusy, expRst, dropWr, dropFlush;
        logic [LANES*ADR-1:0] expRaddr;
        schedState_t          expState;
        logic [DAT:0]         item;
        logic [ADR-1:0]       a;
        @(negedge clk);
        expRd = '0; expWr = 1'b0; dropRd = '0; dropWr = 1'b0; dropFlush = 1'b0;
        expBusy = (phase != 0);
        expAck  = reset && (phase == 3);
        expRst  = !reset || (phase == 2);
        if (reset && phase == 0 && !flushReq) begin
            if (wrReq && (rdReq == '0 || !lastWrite)) expWr = 1'b1;
            else expRd = rdReq;
        end
        expRaddr = '0;
        for (int l = 0; l < LANES; l++)
            if (expRd[l]) expRaddr[l*ADR +: ADR] = rdAddr[l*ADR +: ADR];
        case (phase)
            1:       expState = DRAIN;
            2:       expState = CLEAR;
            3:       expState = ACK;
            default: expState = RUN;
        endcase

        if (doCheck) begin
            chk("wr_gnt", wrGnt, expWr);
            chk("rd_gnt", rdGnt, expRd);
            chk("ram_we", ramWe, expWr);
            chk("ram_re", ramRe, expRd != '0);
            chk("we_re_exclusive", ramWe & ramRe, 0);
            chk("ram_rst", ramRst, expRst);
            chk("busy", busy, expBusy);
            chk("flush_ack", flushAck, expAck);
            chk("state", dbgState, expState);
            chk("ram_raddr", ramRaddr, expRaddr);
            if (expWr) begin
                chk("ram_waddr", ramWaddr, wrAddr);
                chk("ram_wdata", ramWdata, wrData);
            end
            chk("rsp_valid", rspValid, prevGnt);
            for (int l = 0; l < LANES; l++) begin
                if (prevGnt[l]) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_queue_empty", 1, 0);
                    end else begin
                        item = exp_q.pop_front();
                        chk("rsp_line_valid", rspLineValid[l], item[DAT]);
                        if (item[DAT]) chk("rsp_data", rspData[l*DAT +: DAT], item[DAT-1:0]);
                    end
                end else begin
                    chk("rsp_line_valid_idle", rspLineValid[l], 0);
                end
            end
        end

        if (!reset) begin
            phase = 0; lastWrite = 1'b0; refWritten = '0; prevGnt = '0;
            exp_q.delete();
        end else begin
            if (expWr) begin
                refMem[wrAddr]     = wrData;
                refWritten[wrAddr] = 1'b1;
                lastWrite = 1'b1;
                dropWr = 1'b1;
            end
            if (expRd != '0) begin
                for (int l = 0; l < LANES; l++) begin
                    if (expRd[l]) begin
                        a = rdAddr[l*ADR +: ADR];
                        exp_q.push_back({refWritten[a], refMem[a]});
                    end
                end
                lastWrite = 1'b0;
                dropRd = expRd;
            end
            case (phase)
                0: if (flushReq) phase = 1;
                1: phase = 2;
                2: begin phase = 3; refWritten = '0; end
                default: begin phase = 0; dropFlush = 1'b1; end
            endcase
            prevGnt = expRd;
        end

        @(posedge clk);
        #1;
        if (dropWr) wrReq = 1'b0;
        rdReq = rdReq & ~dropRd;
        if (dropFlush) flushReq = 1'b0;
    endtask

    // ---------------- driver helpers ----------------
    task automatic do_reset();
        reset = 1'b0;
        tick(1'b0);
        tick(1'b1);
        reset = 1'b1;
    endtask

    task automatic issue_read(input int lane, input int addr);
        rdReq[lane] = 1'b1;
        rdAddr[lane*ADR +: ADR] = ADR'(addr);
    endtask

    task automatic issue_write(input int addr, input int data);
        wrReq  = 1'b1;
        wrAddr = ADR'(addr);
        wrData = DAT'(data);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vectors = 0; miscompares = 0;
        phase = 0; lastWrite = 1'b0; prevGnt = '0; refWritten = '0;
        rdReq = '0; rdAddr = '0; wrReq = 1'b0; wrAddr = '0; wrData = '0; flushReq = 1'b0;

        do_reset();

        // unwritten line reads back with line_valid low
        issue_read(0, 5);
        tick(1'b1); tick(1'b1);

        // write then read the same line on consecutive cycles
        issue_write(3, 'hA5);
        tick(1'b1);
        issue_read(2, 3);
        tick(1'b1); tick(1'b1);

        // preload and a single four-lane read
        for (int i = 1; i <= 4; i++) begin
            issue_write(i, 'h11 * i);
            tick(1'b1);
        end
        for (int l = 0; l < LANES; l++) issue_read(l, l + 1);
        tick(1'b1); tick(1'b1);

        // sustained conflict alternates write and read
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (!wrReq) issue_write(9, 'h100 + c);
            if (!rdReq[0]) issue_read(0, 9);
            tick(1'b1);
        end
        wrReq = 1'b0; rdReq = '0;
        tick(1'b1); tick(1'b1);

        // flush with a read held across it
        issue_write(7, 'h77);
        tick(1'b1);
        flushReq = 1'b1;
        issue_read(1, 7);
        for (int c = 0; c < 8; c++) tick(1'b1);

        // reset while in CLEAR suppresses the ack
        flushReq = 1'b1;
        tick(1'b1); tick(1'b1);
        reset = 1'b0;
        tick(1'b1);
        reset = 1'b1;
        flushReq = 1'b0;
        tick(1'b1); tick(1'b1);

        // randomized held requests with occasional flushes
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < LANES; l++)
                if (!rdReq[l] && $urandom_range(0, 2) == 0) issue_read(l, $urandom_range(0, 15));
            if (!wrReq && $urandom_range(0, 2) == 0) issue_write($urandom_range(0, 15), $urandom);
            if (!flushReq && $urandom_range(0, 59) == 0) flushReq = 1'b1;
            tick(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
